// File: rtl/video_timing_analyzer.sv
// video_timing_analyzer: measures active/total geometry of a video stream,
// checksums each frame and reports lock once two consecutive frames agree.
module video_timing_analyzer #(
  parameter int CNT_W  = 12,
  parameter int WDOG_W = 22
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET,
  input  logic             CE_PIXEL,
  input  logic [7:0]       VGA_R,
  input  logic [7:0]       VGA_G,
  input  logic [7:0]       VGA_B,
  input  logic             VGA_HS,
  input  logic             VGA_VS,
  input  logic             VGA_DE,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] v_total,
  output logic [15:0]      frame_sum,
  output logic             locked,
  output logic             frame_stb,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_valid
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [WDOG_W-1:0] WMAX = '1;
  state_t            state_q, state_d;
  logic              hs_q, vs_q, de_q;
  logic [CNT_W-1:0]  run_ha_q, run_ha_d, run_ht_q, run_ht_d;
  logic [CNT_W-1:0]  run_va_q, run_va_d, run_vt_q, run_vt_d;
  logic [CNT_W-1:0]  last_ha_q, last_ha_d, last_ht_q, last_ht_d, snap_ha, snap_ht;
  logic [CNT_W-1:0]  h_active_q, h_total_q, v_active_q, v_total_q;
  logic [15:0]       run_sum_q, run_sum_d, frame_sum_q, rgb;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              ovf_q, ovf_d, sat, stb_q, match, latch;
  logic              hs_rise, vs_rise, de_on, de_rise, de_fall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CMAX) ? x : x + 1'b1;
  endfunction

  always_comb begin
    hs_rise   = CE_PIXEL & VGA_HS & ~hs_q;
    vs_rise   = CE_PIXEL & VGA_VS & ~vs_q;
    de_on     = CE_PIXEL & VGA_DE;
    de_rise   = de_on & ~de_q;
    de_fall   = CE_PIXEL & ~VGA_DE & de_q;
    rgb       = 16'(VGA_R) + 16'(VGA_G) + 16'(VGA_B);
    run_ht_d  = !CE_PIXEL ? run_ht_q : hs_rise ? CNT_W'(1) : sat_inc(run_ht_q);
    run_ha_d  = de_rise ? CNT_W'(1) : de_on ? sat_inc(run_ha_q) : run_ha_q;
    last_ha_d = de_fall ? run_ha_q : last_ha_q;
    last_ht_d = hs_rise ? run_ht_q : last_ht_q;
    // a sync edge coinciding with VS rise belongs to the new frame
    run_vt_d  = vs_rise ? CNT_W'(hs_rise) : hs_rise ? sat_inc(run_vt_q) : run_vt_q;
    run_va_d  = vs_rise ? CNT_W'(de_on) : de_rise ? sat_inc(run_va_q) : run_va_q;
    run_sum_d = vs_rise ? (de_on ? rgb : 16'd0) : de_on ? run_sum_q + rgb : run_sum_q;
    sat       = (CE_PIXEL & ~hs_rise & run_ht_q == CMAX) | (de_on & ~de_rise & run_ha_q == CMAX)
              | (hs_rise & ~vs_rise & run_vt_q == CMAX) | (de_rise & ~vs_rise & run_va_q == CMAX);
    ovf_d     = vs_rise ? 1'b0 : ovf_q | sat;
    wdog_d    = vs_rise ? '0 : (CE_PIXEL && wdog_q != WMAX) ? wdog_q + 1'b1 : wdog_q;
    snap_ha   = de_fall ? run_ha_q : last_ha_q;
    snap_ht   = hs_rise ? run_ht_q : last_ht_q;
    match     = snap_ha == h_active_q && snap_ht == h_total_q && run_va_q == v_active_q
              && run_vt_q == v_total_q && !(ovf_q | sat) && run_va_q != '0;
    latch     = vs_rise & (state_q != SEARCH);
  end

  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = vs_rise ? ((state_q == SEARCH || !match) ? MEASURE : LOCKED)
            : (wdog_q == WMAX) ? SEARCH : state_q;
  end

  always_comb begin
    locked    = state_q == LOCKED;
    frame_stb = stb_q;
    h_active  = h_active_q;
    h_total   = h_total_q;
    v_active  = v_active_q;
    v_total   = v_total_q;
    frame_sum = frame_sum_q;
    pix_valid = de_q;
    pix_x     = de_q ? run_ha_q - 1'b1 : '0;
    pix_y     = de_q ? run_va_q - 1'b1 : '0;
  end

  always_ff @(posedge CLK_VIDEO or posedge RESET) begin
    if (RESET) begin
      {hs_q, vs_q, de_q, ovf_q, stb_q} <= '0;
      {run_ha_q, run_ht_q, run_va_q, run_vt_q, last_ha_q, last_ht_q} <= '0;
      {h_active_q, h_total_q, v_active_q, v_total_q} <= '0;
      {run_sum_q, frame_sum_q} <= '0;
      wdog_q <= '0;
    end else begin
      if (CE_PIXEL) {hs_q, vs_q, de_q} <= {VGA_HS, VGA_VS, VGA_DE};
      run_ha_q  <= run_ha_d;
      run_ht_q  <= run_ht_d;
      run_va_q  <= run_va_d;
      run_vt_q  <= run_vt_d;
      last_ha_q <= last_ha_d;
      last_ht_q <= last_ht_d;
      run_sum_q <= run_sum_d;
      ovf_q     <= ovf_d;
      wdog_q    <= wdog_d;
      stb_q     <= latch;
      if (latch) begin
        h_active_q  <= snap_ha;
        h_total_q   <= snap_ht;
        v_active_q  <= run_va_q;
        v_total_q   <= run_vt_q;
        frame_sum_q <= run_sum_q;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_analyzer.sv
// tb_video_timing_analyzer: directed frames on a scaled-down raster (8x6 active, 12x9 total).
module tb_video_timing_analyzer;
  localparam int CW = 8, WW = 10, HA = 8, HT = 12, VA = 6, VT = 9, LONG = 300;
  logic clk = 0, rst = 1, ce = 0, hs = 0, vs = 0, de = 0;
  logic [7:0] r = 0, g = 0, b = 0;
  logic [CW-1:0] h_active, h_total, v_active, v_total, pix_x, pix_y;
  logic [15:0] frame_sum;
  logic locked, frame_stb, pix_valid;
  int n_cmp = 0, n_bad = 0, stb_cnt = 0, stb_long = 0, lock_seen = 0;
  logic stb_prev = 0, last_stb_locked = 0;
  bit chk_on = 0, pv_ok = 0, pv_de = 0;
  int pv_x = 0, pv_y = 0;

  video_timing_analyzer #(.CNT_W(CW), .WDOG_W(WW)) dut (
    .CLK_VIDEO(clk), .RESET(rst), .CE_PIXEL(ce),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de),
    .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
    .frame_sum(frame_sum), .locked(locked), .frame_stb(frame_stb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_stb) begin
      stb_cnt <= stb_cnt + 1;
      last_stb_locked <= locked;
      if (stb_prev) stb_long <= stb_long + 1;
    end
    if (locked) lock_seen <= lock_seen + 1;
    stb_prev <= frame_stb;
  end

  // one pixel: a CE cycle with real values, then per-1 non-CE cycles of junk
  task automatic drive_pix(input logic h, input logic v, input logic d, input int x, input int y, input int per);
    for (int k = 0; k < per; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (chk_on && pv_ok) begin
          n_cmp++;
          if (pix_valid !== pv_de) begin
            n_bad++;
            $display("FAIL pix_valid got %b exp %b", pix_valid, pv_de);
          end
          if (pv_de) begin
            n_cmp++;
            if (pix_x !== CW'(pv_x) || pix_y !== CW'(pv_y)) begin
              n_bad++;
              $display("FAIL pix_xy got (%0d,%0d) exp (%0d,%0d)", pix_x, pix_y, pv_x, pv_y);
            end
          end
        end
        pv_ok = 1; pv_de = d; pv_x = x; pv_y = y;
        ce = 1; hs = h; vs = v; de = d; r = 8'd1; g = 8'd2; b = 8'd3;
      end else begin
        ce = 0;
        {hs, vs, de} = 3'($urandom);
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      end
    end
  endtask

  task automatic frame(input int vact, input int per, input bit long_last, input int stop_at);
    int n = 0;
    for (int l = 0; l < VT; l++) begin
      int len = (long_last && l == VT - 1) ? LONG : HT;
      for (int p = 0; p < len; p++) begin
        if (stop_at >= 0 && n == stop_at) return;
        drive_pix(p < 2, l < 2, (l >= 1 && l <= vact && p >= 3 && p < 3 + HA), p - 3, l - 1, per);
        n++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; ce = 0; hs = 0; vs = 0; de = 0; pv_ok = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({h_active, h_total, v_active, v_total, frame_sum, locked, frame_stb, pix_x, pix_y, pix_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold got %h exp 0", {h_active, h_total, v_active, v_total, frame_sum});
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({locked, frame_stb, pix_valid, h_total} !== '0) begin
      n_bad++;
      $display("FAIL reset_release got %b%b%b/%0d exp 0", locked, frame_stb, pix_valid, h_total);
    end
  endtask

  task automatic test_lock();
    int base = stb_cnt;
    chk_on = 1;
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (stb_cnt - base != 0) begin n_bad++; $display("FAIL lock_first_vs got %0d strobes exp 0", stb_cnt - base); end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (stb_cnt - base != 1 || locked !== 1'b0 || last_stb_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_second_vs got stb=%0d locked=%b exp stb=1 locked=0", stb_cnt - base, locked);
    end
    n_cmp++;
    if ({h_active, h_total, v_active, v_total, frame_sum} !== {CW'(HA), CW'(HT), CW'(VA), CW'(VT), 16'd288}) begin
      n_bad++;
      $display("FAIL lock_meas got %h exp %h", {h_active, h_total, v_active, v_total, frame_sum},
               {CW'(HA), CW'(HT), CW'(VA), CW'(VT), 16'd288});
    end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (stb_cnt - base != 2 || locked !== 1'b1 || last_stb_locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_third_vs got stb=%0d locked=%b exp stb=2 locked=1", stb_cnt - base, locked);
    end
    n_cmp++;
    if (stb_long != 0) begin n_bad++; $display("FAIL stb_width got %0d long pulses exp 0", stb_long); end
    chk_on = 0;
  endtask

  task automatic test_short_frame();
    frame(VA - 1, 1, 0, -1);
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (v_active !== CW'(VA - 1) || frame_sum !== 16'd240 || locked !== 1'b0 || last_stb_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL short_frame got v_act=%0d sum=%0d locked=%b exp 5/240/0", v_active, frame_sum, locked);
    end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (v_active !== CW'(VA) || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL short_recover1 got v_act=%0d locked=%b exp 6/0", v_active, locked);
    end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL short_relock got %b exp 1", locked); end
  endtask

  task automatic test_ce();
    int base;
    do_reset();
    base = stb_cnt;
    chk_on = 1;
    repeat (3) frame(VA, 4, 0, -1);
    chk_on = 0;
    n_cmp++;
    if ({h_active, h_total, v_active, v_total, frame_sum} !== {CW'(HA), CW'(HT), CW'(VA), CW'(VT), 16'd288}) begin
      n_bad++;
      $display("FAIL ce_meas got %h exp %h", {h_active, h_total, v_active, v_total, frame_sum},
               {CW'(HA), CW'(HT), CW'(VA), CW'(VT), 16'd288});
    end
    n_cmp++;
    if (stb_cnt - base != 2 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL ce_lock got stb=%0d locked=%b exp 2/1", stb_cnt - base, locked);
    end
  endtask

  task automatic test_watchdog();
    int base = stb_cnt;
    for (int i = 0; i < 1100; i++) drive_pix(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (locked !== 1'b0 || stb_cnt != base) begin
      n_bad++;
      $display("FAIL wdog_drop got locked=%b stb=%0d exp 0/0", locked, stb_cnt - base);
    end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (stb_cnt != base) begin n_bad++; $display("FAIL wdog_search got stb=%0d exp 0", stb_cnt - base); end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (stb_cnt - base != 1) begin n_bad++; $display("FAIL wdog_remeasure got stb=%0d exp 1", stb_cnt - base); end
  endtask

  task automatic test_overflow();
    int base, lb;
    do_reset();
    base = stb_cnt;
    lb = lock_seen;
    repeat (4) frame(VA, 1, 1, -1);
    n_cmp++;
    if (h_total !== CW'(255) || h_active !== CW'(HA) || v_total !== CW'(VT)) begin
      n_bad++;
      $display("FAIL ovf_meas got h_tot=%0d h_act=%0d v_tot=%0d exp 255/8/9", h_total, h_active, v_total);
    end
    n_cmp++;
    if (stb_cnt - base != 3 || lock_seen != lb) begin
      n_bad++;
      $display("FAIL ovf_nolock got stb=%0d lock_cycles=%0d exp 3/0", stb_cnt - base, lock_seen - lb);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    repeat (3) frame(VA, 1, 0, -1);
    frame(VA, 1, 0, 40);
    @(posedge clk);
    #2 ce = 0;
    n_cmp++;
    if (locked !== 1'b1 || pix_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pre got locked=%b pix_valid=%b exp 1/1", locked, pix_valid);
    end
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({h_active, h_total, v_active, v_total, frame_sum, locked, frame_stb, pix_x, pix_y, pix_valid} !== '0) begin
      n_bad++;
      $display("FAIL rmid_zero got %h locked=%b pix_valid=%b exp 0", {h_active, h_total, v_active, v_total, frame_sum}, locked, pix_valid);
    end
    repeat (2) @(negedge clk);
    rst = 0; pv_ok = 0;
    base = stb_cnt;
    repeat (2) frame(VA, 1, 0, -1);
    n_cmp++;
    if (locked !== 1'b0 || stb_cnt - base != 1) begin
      n_bad++;
      $display("FAIL rmid_measure got locked=%b stb=%0d exp 0/1", locked, stb_cnt - base);
    end
    frame(VA, 1, 0, -1);
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL rmid_relock got %b exp 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_frame();
    test_ce();
    test_watchdog();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
